uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage. It is the downstream counterpart of the team's UART transmit stage and consumes its serial line output (8N1, LSB first, idle high).
- Oversamples the asynchronous rx line using an external 16x-baud enable pulse.
- Qualifies the start bit at mid-bit and samples each data bit at mid-bit.
- Checks the stop bit and presents a byte with a one-cycle valid strobe or a framing-error strobe.

---
 rtl/uart_receiver_if.sv | 30 +++
 rtl/uart_receiver.sv | 144 ++++++++++++++
 tb/tb_uart_receiver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Serial-receive bundle: the line and oversample enable in, the
// recovered byte and its status strobes out.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_en;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_busy;

    modport master (
        output sample_en,
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  sample_en,
        input  rx_in,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: oversamples rx_in on sample_en, samples at
// mid-bit, and reports each frame with a valid or framing-error strobe.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_receiver_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_T   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_T   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t               state, state_d;
    logic                 sync_q1, rx_s;
    logic [TW-1:0]        tick_cnt, tick_d;
    logic [BW-1:0]        bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shift_reg, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    // Synchronizer resets to the idle-high level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= bus.rx_in;
            rx_s    <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_d;
            tick_cnt  <= tick_d;
            bit_cnt   <= bit_d;
            shift_reg <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state;
        tick_d  = tick_cnt;
        bit_d   = bit_cnt;
        shift_d = shift_reg;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sample_en && !rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (bus.sample_en) begin
                    if (tick_cnt == HALF_T) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.sample_en) begin
                    if (tick_cnt == FULL_T) begin
                        tick_d                = '0;
                        shift_d               = shift_reg >> 1;
                        shift_d[DATA_BITS-1]  = rx_s;
                        bit_d                 = bit_cnt + BW'(1);
                        if (bit_d == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (bus.sample_en) begin
                    if (tick_cnt == FULL_T) begin
                        tick_d = '0;
                        if (rx_s) begin
                            data_d  = shift_reg;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_cnt + TW'(1);
                    end
                end
            end
            // A line held low after a bad stop bit must go high before a new start counts.
            BREAK: begin
                if (bus.sample_en && rx_s) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frames against a frame-level model of the
// receiver: each good frame yields its byte, each low stop bit one error.
module tb_uart_receiver;
    localparam int BIT_CLK = 64;

    logic clk;
    logic rst_n;

    uart_receiver_if #(.DATA_BITS(8)) bus ();

    uart_receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         exp_ferr  = 0;
    int         obs_ferr  = 0;
    int         obs_both  = 0;
    logic [7:0] last_good = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock enable every fourth clock: 16 per 64-clock bit.
    initial begin
        bus.sample_en = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.sample_en = 1'b1;
            @(negedge clk);
            bus.sample_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.rx_valid) obs_q.push_back(bus.rx_data);
        if (bus.rx_frame_err) obs_ferr++;
        if (bus.rx_valid && bus.rx_frame_err) obs_both++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic hold_line(input logic level, input int clocks);
        bus.rx_in = level;
        repeat (clocks) @(negedge clk);
    endtask

    // Behavioural transmitter plus the model's view of what that frame must produce.
    task automatic apply_stimulus(input logic [7:0] value, input logic stop_bit,
                                  input int period);
        hold_line(1'b0, period);
        for (int i = 0; i < 8; i++) hold_line(value[i], period);
        hold_line(stop_bit, period);
        if (stop_bit) begin
            exp_q.push_back(value);
            last_good = value;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_strobes(input string tag);
        int n;
        check_output({tag, "_valid_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
        check_output({tag, "_ferr_count"}, obs_ferr, exp_ferr);
        check_output({tag, "_both_strobes"}, obs_both, 0);
        check_output({tag, "_rx_data"}, bus.rx_data, last_good);
        check_output({tag, "_busy"}, bus.rx_busy, 1'b0);
    endtask

    initial begin
        logic [7:0] loop_bytes[4];
        logic [7:0] b;
        logic       s;
        int         p;

        bus.rx_in = 1'b1;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        check_output("reset_rx_data", bus.rx_data, 8'h00);
        check_output("reset_valid", bus.rx_valid, 1'b0);
        check_output("reset_ferr", bus.rx_frame_err, 1'b0);
        check_output("reset_busy", bus.rx_busy, 1'b0);
        rst_n = 1'b1;
        hold_line(1'b1, 2 * BIT_CLK);

        apply_stimulus(8'hA5, 1'b1, BIT_CLK);
        hold_line(1'b1, BIT_CLK);
        check_strobes("single_a5");

        hold_line(1'b0, 20);
        hold_line(1'b1, 2 * BIT_CLK);
        check_strobes("glitch");

        apply_stimulus(8'h3C, 1'b0, BIT_CLK);
        hold_line(1'b0, 160);
        check_output("break_busy", bus.rx_busy, 1'b1);
        check_output("break_ferr_once", obs_ferr, exp_ferr);
        hold_line(1'b1, BIT_CLK);
        check_strobes("framing");
        apply_stimulus(8'hC3, 1'b1, BIT_CLK);
        hold_line(1'b1, BIT_CLK);
        check_strobes("after_break");

        apply_stimulus(8'h00, 1'b1, BIT_CLK);
        apply_stimulus(8'hFF, 1'b1, BIT_CLK);
        hold_line(1'b1, BIT_CLK);
        check_strobes("back_to_back");

        b = 8'h5A;
        hold_line(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold_line(b[i], BIT_CLK);
        hold_line(b[4], BIT_CLK / 2);
        rst_n = 1'b0;
        hold_line(1'b1, 4);
        last_good = 8'h00;
        check_output("midreset_rx_data", bus.rx_data, 8'h00);
        check_output("midreset_busy", bus.rx_busy, 1'b0);
        rst_n = 1'b1;
        hold_line(1'b1, BIT_CLK);
        apply_stimulus(8'h81, 1'b1, BIT_CLK);
        hold_line(1'b1, BIT_CLK);
        check_strobes("after_reset");

        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'h55;
        loop_bytes[2] = 8'hAA;
        loop_bytes[3] = 8'hFF;
        for (int k = 0; k < 4; k++) apply_stimulus(loop_bytes[k], 1'b1, 62);
        for (int k = 0; k < 4; k++) apply_stimulus(loop_bytes[k], 1'b1, 66);
        hold_line(1'b1, BIT_CLK);
        check_strobes("loopback_skew");

        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            p = 62 + 2 * $urandom_range(0, 2);
            apply_stimulus(b, s, p);
            if (!s) begin
                hold_line(1'b0, BIT_CLK * $urandom_range(0, 2));
                hold_line(1'b1, BIT_CLK + $urandom_range(0, 32));
            end else begin
                hold_line(1'b1, $urandom_range(0, BIT_CLK));
            end
        end
        hold_line(1'b1, BIT_CLK);
        check_strobes("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
